// File: rtl/spi_sphere_packer.sv
// Packs SPI bytes framed by cs_n into 64-bit sphere words, holds one word for the controller, returns ack/NAK status.
// Optional: define SPI_PACKER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module spi_sphere_packer #(
    parameter int         FRAME_BYTES = 8,
    parameter logic [7:0] ACK_BYTE    = 8'hA5,
    parameter logic [7:0] NAK_OVR     = 8'hEE,
    parameter logic [7:0] NAK_FRM     = 8'hFE
) (
    input  logic        CLK100MHZ,
    input  logic        ck_rst,
    input  logic        rx_dv,
    input  logic [7:0]  rx_byte,
    input  logic        cs_n,
    input  logic        recv_interrupt,
    output logic        recv_dv,
    output logic [63:0] recv_64bit,
    output logic        tran_dv,
    output logic [7:0]  tran_byte,
    output logic        overrun
);

    localparam logic [3:0] PAYLOAD_LEN = 4'(FRAME_BYTES);
`ifdef SPI_PACKER_CHECKSUM_EN
    localparam logic [3:0] FRAME_LEN = 4'(FRAME_BYTES + 1);
`else
    localparam logic [3:0] FRAME_LEN = 4'(FRAME_BYTES);
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, CHECK = 2'd2} state_t;

    state_t      state, state_next;
    logic        cs_meta, cs_s, cs_s_d;
    logic [3:0]  cnt;
    logic        too_long;
    logic [63:0] shift_reg;
    logic [63:0] hold;
    logic        hold_valid;
    logic        ack_pend;
`ifdef SPI_PACKER_CHECKSUM_EN
    logic [7:0]  csum_acc;
    logic [7:0]  csum_byte;
`endif

    logic cs_fall, cs_rise, deliver, frame_ok;
    logic clr_frame, store_byte, set_long, nak_frm, nak_ovr, accept;

    assign cs_fall = cs_s_d & ~cs_s;
    assign cs_rise = ~cs_s_d & cs_s;
    assign deliver = hold_valid & recv_interrupt;
`ifdef SPI_PACKER_CHECKSUM_EN
    assign frame_ok = (cnt == FRAME_LEN) && !too_long && (csum_byte == csum_acc);
`else
    assign frame_ok = (cnt == FRAME_LEN) && !too_long;
`endif

    // Synchronizer resets to deasserted so a frame cannot appear out of reset.
    always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
        if (ck_rst) begin
            cs_meta <= 1'b1;
            cs_s    <= 1'b1;
            cs_s_d  <= 1'b1;
        end else begin
            cs_meta <= cs_n;
            cs_s    <= cs_meta;
            cs_s_d  <= cs_s;
        end
    end

    always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
        if (ck_rst) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        clr_frame  = 1'b0;
        store_byte = 1'b0;
        set_long   = 1'b0;
        nak_frm    = 1'b0;
        nak_ovr    = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                clr_frame = 1'b1;
                if (cs_fall) state_next = COLLECT;
            end
            COLLECT: begin
                if (cs_fall) begin
                    clr_frame = 1'b1;
                end else if (cs_rise) begin
                    if (frame_ok) begin
                        state_next = CHECK;
                    end else begin
                        nak_frm    = 1'b1;
                        state_next = IDLE;
                    end
                end else if (rx_dv) begin
                    if (cnt == FRAME_LEN) set_long   = 1'b1;
                    else                  store_byte = 1'b1;
                end
            end
            CHECK: begin
                state_next = IDLE;
                // A delivery in this same cycle empties the buffer in time.
                if (!hold_valid || deliver) accept  = 1'b1;
                else                        nak_ovr = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
        if (ck_rst) begin
            cnt       <= '0;
            too_long  <= 1'b0;
            shift_reg <= '0;
`ifdef SPI_PACKER_CHECKSUM_EN
            csum_acc  <= '0;
            csum_byte <= '0;
`endif
        end else if (clr_frame) begin
            cnt      <= '0;
            too_long <= 1'b0;
`ifdef SPI_PACKER_CHECKSUM_EN
            csum_acc <= '0;
`endif
        end else if (set_long) begin
            too_long <= 1'b1;
        end else if (store_byte) begin
            cnt <= cnt + 4'd1;
`ifdef SPI_PACKER_CHECKSUM_EN
            if (cnt < PAYLOAD_LEN) begin
                shift_reg <= {shift_reg[55:0], rx_byte};
                csum_acc  <= csum_acc ^ rx_byte;
            end else begin
                csum_byte <= rx_byte;
            end
`else
            if (cnt < PAYLOAD_LEN) shift_reg <= {shift_reg[55:0], rx_byte};
`endif
        end
    end

    always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
        if (ck_rst) begin
            hold       <= '0;
            hold_valid <= 1'b0;
            recv_dv    <= 1'b0;
            recv_64bit <= '0;
            overrun    <= 1'b0;
        end else begin
            recv_dv <= deliver;
            if (deliver) recv_64bit <= hold;
            if (accept) begin
                hold       <= shift_reg;
                hold_valid <= 1'b1;
            end else if (deliver) begin
                hold_valid <= 1'b0;
            end
            if (nak_ovr) overrun <= 1'b1;
        end
    end

    // NAK wins the transmit slot; a colliding ack is deferred one cycle.
    always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
        if (ck_rst) begin
            tran_dv   <= 1'b0;
            tran_byte <= '0;
            ack_pend  <= 1'b0;
        end else begin
            tran_dv <= 1'b0;
            if (nak_frm || nak_ovr) begin
                tran_dv   <= 1'b1;
                tran_byte <= nak_frm ? NAK_FRM : NAK_OVR;
                ack_pend  <= ack_pend | deliver;
            end else if (deliver || ack_pend) begin
                tran_dv   <= 1'b1;
                tran_byte <= ACK_BYTE;
                ack_pend  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_sphere_packer.sv
// Scoreboard bench for spi_sphere_packer: expected words/status bytes are queued at stimulus time and popped on DUT strobes.
module tb_spi_sphere_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_byte = '0;
    logic        cs_n = 1'b1;
    logic        recv_interrupt = 1'b0;
    logic        recv_dv;
    logic [63:0] recv_64bit;
    logic        tran_dv;
    logic [7:0]  tran_byte;
    logic        overrun;

    logic [63:0] exp_word_q[$];
    logic [7:0]  exp_tran_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          last_recv_cyc = -1;
    int          rise_cyc = 0;
    logic [7:0]  frame_buf[16];

    spi_sphere_packer dut (
        .CLK100MHZ     (clk),
        .ck_rst        (rst),
        .rx_dv         (rx_dv),
        .rx_byte       (rx_byte),
        .cs_n          (cs_n),
        .recv_interrupt(recv_interrupt),
        .recv_dv       (recv_dv),
        .recv_64bit    (recv_64bit),
        .tran_dv       (tran_dv),
        .tran_byte     (tran_byte),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor samples 1 time unit after each active edge.
    always begin
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        if (recv_dv) begin
            last_recv_cyc = cyc;
            if (exp_word_q.size() == 0) check("recv_unexpected", 64'd1, 64'd0);
            else check("recv_64bit", recv_64bit, exp_word_q.pop_front());
        end
        if (tran_dv) begin
            if (exp_tran_q.size() == 0) check("tran_unexpected", {56'd0, tran_byte}, 64'd0);
            else check("tran_byte", {56'd0, tran_byte}, {56'd0, exp_tran_q.pop_front()});
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(negedge clk);
        rx_dv   = 1'b0;
        rx_byte = $urandom_range(0, 255);
    endtask

    task automatic send_raw(input int n);
        @(negedge clk);
        cs_n = 1'b0;
        wait_cycles(5);
        for (int i = 0; i < n; i++) send_byte(frame_buf[i]);
        @(negedge clk);
        cs_n = 1'b1;
        wait_cycles(8);
    endtask

    task automatic send_word(input logic [63:0] w);
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < 8; i++) begin
            frame_buf[i] = w[63 - 8*i -: 8];
            x = x ^ frame_buf[i];
        end
`ifdef SPI_PACKER_CHECKSUM_EN
        frame_buf[8] = x;
        send_raw(9);
`else
        send_raw(8);
`endif
    endtask

    initial begin
        logic [63:0] w_a, w_b, w_c;
        int guard;
        wait_cycles(3);
        check("rst_recv_dv", {63'd0, recv_dv}, 64'd0);
        check("rst_recv_64bit", recv_64bit, 64'd0);
        check("rst_tran_dv", {63'd0, tran_dv}, 64'd0);
        check("rst_tran_byte", {56'd0, tran_byte}, 64'd0);
        check("rst_overrun", {63'd0, overrun}, 64'd0);
        rst = 1'b0;
        wait_cycles(3);

        // Basic delivery, controller ready.
        recv_interrupt = 1'b1;
        exp_word_q.push_back(64'h0102030405060708);
        exp_tran_q.push_back(8'hA5);
        send_word(64'h0102030405060708);
        wait_cycles(4);

        // Word waits for recv_interrupt; delivery 1 cycle after the rise.
        recv_interrupt = 1'b0;
        w_a = {$urandom(), $urandom()};
        send_word(w_a);
        exp_word_q.push_back(w_a);
        exp_tran_q.push_back(8'hA5);
        wait_cycles(500);
        check("no_early_recv", exp_word_q.size(), 64'd1);
        recv_interrupt = 1'b1;
        rise_cyc = cyc;
        wait_cycles(4);
        check("recv_latency", 64'(last_recv_cyc - rise_cyc), 64'd1);

        // Two frames without controller: second dropped, first kept.
        recv_interrupt = 1'b0;
        w_b = {$urandom(), $urandom()};
        w_c = {$urandom(), $urandom()};
        send_word(w_b);
        exp_tran_q.push_back(8'hEE);
        send_word(w_c);
        check("overrun_set", {63'd0, overrun}, 64'd1);
        exp_word_q.push_back(w_b);
        exp_tran_q.push_back(8'hA5);
        recv_interrupt = 1'b1;
        wait_cycles(4);

        // Short and long frames are NAKed (01..09 is also a bad checksum when enabled).
        for (int i = 0; i < 16; i++) frame_buf[i] = 8'(i + 1);
        exp_tran_q.push_back(8'hFE);
        send_raw(5);
        check("idle_after_short", 64'(dut.state), 64'd0);
        exp_tran_q.push_back(8'hFE);
`ifdef SPI_PACKER_CHECKSUM_EN
        send_raw(10);
`else
        send_raw(9);
`endif
        check("idle_after_long", 64'(dut.state), 64'd0);
`ifdef SPI_PACKER_CHECKSUM_EN
        exp_tran_q.push_back(8'hFE);
        send_raw(9);
`endif

        // Reset mid-frame discards partial frame and clears sticky flags.
        @(negedge clk);
        cs_n = 1'b0;
        wait_cycles(5);
        for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i));
        rst  = 1'b1;
        cs_n = 1'b1;
        wait_cycles(3);
        check("rst2_overrun", {63'd0, overrun}, 64'd0);
        check("rst2_recv_64bit", recv_64bit, 64'd0);
        check("rst2_state", 64'(dut.state), 64'd0);
        rst = 1'b0;
        wait_cycles(4);
        w_a = {$urandom(), $urandom()};
        exp_word_q.push_back(w_a);
        exp_tran_q.push_back(8'hA5);
        send_word(w_a);

        guard = 0;
        while ((exp_word_q.size() != 0 || exp_tran_q.size() != 0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("words_left", exp_word_q.size(), 64'd0);
        check("trans_left", exp_tran_q.size(), 64'd0);
        wait_cycles(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
